// File: rtl/span_layer_renderer.sv
// Animated horizontal span renderer: NUM_BANDS vertical bands of SPANS span pairs,
// positions driven by a double-buffered {rate, base} table and a frame counter.
module span_layer_renderer #(
    parameter int unsigned NUM_BANDS = 8,
    parameter int unsigned SPANS     = 2,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned RATE_W    = 8,
    parameter int unsigned FRAME_W   = 9,
    parameter int unsigned COLOUR_W  = 6,
    localparam int unsigned E        = 2 * SPANS,
    localparam int unsigned ADDR_W   = $clog2(NUM_BANDS * (E + 1)),
    localparam int unsigned ENTRY_W  = COORD_W + RATE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COORD_W-1:0]  x_pos,
    input  logic [COORD_W-1:0]  y_pos,
    input  logic                hblank,
    input  logic                next_row,
    input  logic                vsync_pulse,
    input  logic                frame_run,
    input  logic                frame_clr,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [ENTRY_W-1:0]  cfg_wdata,
    input  logic [COLOUR_W-1:0] fg_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic [FRAME_W-1:0]  frame,
    output logic [COLOUR_W-1:0] colour
);

    localparam int unsigned STRIDE = E + 1;
    localparam int unsigned TBL    = NUM_BANDS * STRIDE;
    localparam int unsigned FRAC   = 5;
    localparam int unsigned BAND_W = $clog2(NUM_BANDS + 1);
    localparam int unsigned EDGE_W = $clog2(E + 1);
    localparam int unsigned PROD_W = RATE_W + FRAME_W + 1;

    logic [ENTRY_W-1:0] shadow_tbl [TBL];
    logic [ENTRY_W-1:0] active_tbl [TBL];

    logic               clr_pending;
    logic [BAND_W-1:0]  band;
    logic [EDGE_W-1:0]  edge_idx;
    logic               in_span;

    logic                      y_sel_c;
    logic                      sel_valid_c;
    logic [ADDR_W-1:0]         sel_addr_c;
    logic [ENTRY_W-1:0]        entry_c;
    logic signed [RATE_W-1:0]  rate_c;
    logic signed [PROD_W-1:0]  rate_x_c;
    logic signed [PROD_W-1:0]  frame_x_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic [COORD_W-1:0]        pos_c;
    logic [COORD_W-1:0]        cmp_c;
    logic                      match_c;

    // Shared comparator: Y start of the band pointer during blanking, else current X edge.
    always_comb begin
        y_sel_c     = next_row | hblank;
        sel_valid_c = 1'b0;
        sel_addr_c  = '0;
        entry_c     = '0;
        if (y_sel_c) begin
            sel_valid_c = (band < BAND_W'(NUM_BANDS));
            sel_addr_c  = ADDR_W'(band) * ADDR_W'(STRIDE);
        end else begin
            sel_valid_c = (band != '0) && (edge_idx < EDGE_W'(E));
            sel_addr_c  = ADDR_W'(band - BAND_W'(1)) * ADDR_W'(STRIDE)
                        + ADDR_W'(1) + ADDR_W'(edge_idx);
        end
        if (32'(sel_addr_c) < TBL)
            entry_c = active_tbl[sel_addr_c];
        rate_c    = entry_c[ENTRY_W-1:COORD_W];
        rate_x_c  = PROD_W'(rate_c);
        frame_x_c = PROD_W'({1'b0, frame});
        prod_c    = rate_x_c * frame_x_c;
        pos_c     = entry_c[COORD_W-1:0] + COORD_W'(prod_c >>> FRAC);
        cmp_c     = y_sel_c ? y_pos : x_pos;
        match_c   = sel_valid_c && (pos_c == cmp_c);
    end

    // Shadow takes writes; active is refreshed from shadow (plus any same-cycle write) on vsync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TBL; i++) begin
                shadow_tbl[i] <= '0;
                active_tbl[i] <= '0;
            end
        end else begin
            if (cfg_we && (32'(cfg_addr) < TBL))
                shadow_tbl[cfg_addr] <= cfg_wdata;
            if (vsync_pulse) begin
                for (int unsigned i = 0; i < TBL; i++)
                    active_tbl[i] <= (cfg_we && (32'(cfg_addr) == i)) ? cfg_wdata : shadow_tbl[i];
            end
        end
    end

    // Frame counter with deferred clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame       <= '0;
            clr_pending <= 1'b0;
        end else if (vsync_pulse) begin
            frame       <= (clr_pending | frame_clr) ? '0 : frame + FRAME_W'(frame_run);
            clr_pending <= 1'b0;
        end else if (frame_clr) begin
            clr_pending <= 1'b1;
        end
    end

    // Band / edge pointers and span state; vsync wins over comparator updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band     <= '0;
            edge_idx <= '0;
            in_span  <= 1'b0;
        end else if (vsync_pulse) begin
            band     <= '0;
            edge_idx <= '0;
            in_span  <= 1'b0;
        end else if (y_sel_c) begin
            edge_idx <= '0;
            in_span  <= 1'b0;
            if (match_c)
                band <= band + BAND_W'(1);
        end else if (match_c) begin
            edge_idx <= edge_idx + EDGE_W'(1);
            in_span  <= ~in_span;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            colour <= '0;
        else
            colour <= in_span ? fg_colour : bg_colour;
    end

endmodule
